// File: rtl/a2_disk_pkg.sv
// a2_disk_pkg: shared floppy-disk definitions (track controller state, default sectors per track)
package a2_disk_pkg;

    localparam int SECS_PER_TRACK_DEF = 13;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        LOAD
    } fdd_state_t;

endpackage

// File: rtl/fdd_track_ctrl.sv
// fdd_track_ctrl: buffers one nibble track, loading it from and writing it back to the HPS disk channel
//   clk_sys, reset_n      : sole clock, asynchronous active-low reset
//   img_mounted/present/readonly : image mount pulse and image status
//   track, core_wr        : head track requested by the core, track-RAM write pulse
//   sd_lba, sd_rd, sd_wr, sd_ack : block request handshake to the HPS
//   track_sec             : sector within the track (upper track-RAM address)
//   cpu_wait, dirty       : CPU stall while the buffer is invalid, unsaved-write flag
module fdd_track_ctrl
    import a2_disk_pkg::*;
#(
    parameter int SECS_PER_TRACK = SECS_PER_TRACK_DEF,
    parameter int TRACK_W        = 6
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               img_mounted,
    input  logic               img_present,
    input  logic               img_readonly,
    input  logic [TRACK_W-1:0] track,
    input  logic               core_wr,
    output logic [31:0]        sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    input  logic               sd_ack,
    output logic [3:0]         track_sec,
    output logic               cpu_wait,
    output logic               dirty
);

    localparam int PW = TRACK_W + 4;

    fdd_state_t         state, state_nxt;
    logic [TRACK_W-1:0] cur_track, cur_track_nxt;
    logic               valid, valid_nxt;
    logic               remount_pend, remount_pend_nxt;
    logic               dirty_nxt, sd_rd_nxt, sd_wr_nxt, cpu_wait_nxt;
    logic [3:0]         track_sec_nxt;
    logic               ack_d;
    logic [PW-1:0]      base;

    wire ack_rise = sd_ack & ~ack_d;
    wire ack_fall = ~sd_ack & ack_d;
    wire last_sec = track_sec == 4'(SECS_PER_TRACK - 1);

    assign base   = PW'(SECS_PER_TRACK) * PW'(cur_track);
    assign sd_lba = 32'(base) + 32'(track_sec);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cur_track    <= '0;
            valid        <= 1'b0;
            remount_pend <= 1'b0;
            dirty        <= 1'b0;
            sd_rd        <= 1'b0;
            sd_wr        <= 1'b0;
            cpu_wait     <= 1'b0;
            track_sec    <= '0;
            ack_d        <= 1'b0;
        end else begin
            state        <= state_nxt;
            cur_track    <= cur_track_nxt;
            valid        <= valid_nxt;
            remount_pend <= remount_pend_nxt;
            dirty        <= dirty_nxt;
            sd_rd        <= sd_rd_nxt;
            sd_wr        <= sd_wr_nxt;
            cpu_wait     <= cpu_wait_nxt;
            track_sec    <= track_sec_nxt;
            ack_d        <= sd_ack;
        end
    end

    always_comb begin
        state_nxt        = state;
        cur_track_nxt    = cur_track;
        valid_nxt        = valid;
        remount_pend_nxt = remount_pend;
        dirty_nxt        = dirty;
        sd_rd_nxt        = sd_rd;
        sd_wr_nxt        = sd_wr;
        cpu_wait_nxt     = cpu_wait;
        track_sec_nxt    = track_sec;
        unique case (state)
            IDLE: begin
                // A remount discards the buffer outright, so no write-back happens here.
                if (remount_pend || img_mounted) begin
                    dirty_nxt        = 1'b0;
                    valid_nxt        = 1'b0;
                    remount_pend_nxt = 1'b0;
                    if (img_present) begin
                        cur_track_nxt = track;
                        state_nxt     = LOAD;
                        track_sec_nxt = '0;
                        sd_rd_nxt     = 1'b1;
                        cpu_wait_nxt  = 1'b1;
                    end
                end else if (valid && track != cur_track) begin
                    track_sec_nxt = '0;
                    cpu_wait_nxt  = 1'b1;
                    if (dirty && !img_readonly) begin
                        state_nxt = WB;
                        sd_wr_nxt = 1'b1;
                    end else begin
                        cur_track_nxt = track;
                        state_nxt     = LOAD;
                        sd_rd_nxt     = 1'b1;
                    end
                end else if (!valid && img_present) begin
                    cur_track_nxt = track;
                    state_nxt     = LOAD;
                    track_sec_nxt = '0;
                    sd_rd_nxt     = 1'b1;
                    cpu_wait_nxt  = 1'b1;
                end else if (core_wr && valid && !img_readonly) begin
                    dirty_nxt = 1'b1;
                end
            end
            WB, LOAD: begin
                if (img_mounted) remount_pend_nxt = 1'b1;
                if (ack_rise) begin
                    sd_rd_nxt = 1'b0;
                    sd_wr_nxt = 1'b0;
                end
                if (ack_fall) begin
                    if (!last_sec) begin
                        track_sec_nxt = track_sec + 4'd1;
                        sd_rd_nxt     = state == LOAD;
                        sd_wr_nxt     = state == WB;
                    end else if (state == WB) begin
                        // Write-back done: fetch whatever track the head is on now.
                        dirty_nxt     = 1'b0;
                        cur_track_nxt = track;
                        state_nxt     = LOAD;
                        track_sec_nxt = '0;
                        sd_rd_nxt     = 1'b1;
                        sd_wr_nxt     = 1'b0;
                    end else begin
                        valid_nxt    = 1'b1;
                        cpu_wait_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fdd_track_ctrl.sv
// tb_fdd_track_ctrl: directed and randomized checks of fdd_track_ctrl against a track-level reference model
module tb_fdd_track_ctrl;

    localparam int SPT = 13;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        img_mounted = 1'b0;
    logic        img_present = 1'b0;
    logic        img_readonly = 1'b0;
    logic        core_wr = 1'b0;
    logic        sd_ack = 1'b0;
    logic [5:0]  track = '0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, cpu_wait, dirty;
    logic [3:0]  track_sec;

    int checks = 0;
    int errors = 0;
    int got_lba[$];
    bit got_wr[$];
    int exp_lba[$];
    bit exp_wr[$];
    int m_cur;
    bit m_dirty;

    always #5 clk_sys = ~clk_sys;

    fdd_track_ctrl #(.SECS_PER_TRACK(SPT), .TRACK_W(6)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .img_mounted(img_mounted),
        .img_present(img_present),
        .img_readonly(img_readonly),
        .track(track),
        .core_wr(core_wr),
        .sd_lba(sd_lba),
        .sd_rd(sd_rd),
        .sd_wr(sd_wr),
        .sd_ack(sd_ack),
        .track_sec(track_sec),
        .cpu_wait(cpu_wait),
        .dirty(dirty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // HPS responder: logs every request, then acks it after random delays.
    initial begin
        int phase = 0;
        int cnt = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                sd_ack = 1'b0;
                phase = 0;
            end else if (phase == 0) begin
                if (sd_rd || sd_wr) begin
                    chk("rd_wr_exclusive", 32'(sd_rd & sd_wr), 0);
                    chk("wait_during_req", 32'(cpu_wait), 1);
                    got_wr.push_back(sd_wr);
                    got_lba.push_back(int'(sd_lba));
                    cnt = int'($urandom_range(0, 2));
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (cnt == 0) begin
                    sd_ack = 1'b1;
                    cnt = int'($urandom_range(1, 3));
                    phase = 2;
                end else cnt--;
            end else begin
                if (cnt == 0) begin
                    sd_ack = 1'b0;
                    phase = 0;
                end else cnt--;
            end
        end
    end

    task automatic expect_track(input bit wr, input int t);
        for (int i = 0; i < SPT; i++) begin
            exp_wr.push_back(wr);
            exp_lba.push_back(SPT * t + i);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int m;
        while (!(got_lba.size() >= exp_lba.size() && !cpu_wait && !sd_rd && !sd_wr) && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 3000), 1);
        chk({tag, "_count"}, got_lba.size(), exp_lba.size());
        m = got_lba.size() < exp_lba.size() ? got_lba.size() : exp_lba.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_lba"}, got_lba[i], exp_lba[i]);
            chk({tag, "_dir"}, 32'(got_wr[i]), 32'(exp_wr[i]));
        end
        got_lba.delete();
        got_wr.delete();
        exp_lba.delete();
        exp_wr.delete();
    endtask

    task automatic wait_sec(input bit wr, input int s);
        int n = 0;
        while (!((wr ? sd_wr : sd_rd) && int'(track_sec) == s) && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("sector_reached", 32'(n < 3000), 1);
    endtask

    task automatic pulse_wr();
        core_wr = 1'b1;
        @(negedge clk_sys);
        core_wr = 1'b0;
    endtask

    initial begin
        int t;
        bit ro;
        repeat (3) @(negedge clk_sys);
        chk("rst_rd", 32'(sd_rd), 0);
        chk("rst_wr", 32'(sd_wr), 0);
        chk("rst_wait", 32'(cpu_wait), 0);
        chk("rst_dirty", 32'(dirty), 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_sec", 32'(track_sec), 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        // cold load of track 0
        track = 6'd0;
        img_present = 1'b1;
        img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        chk("cold_wait", 32'(cpu_wait), 1);
        chk("cold_rd", 32'(sd_rd), 1);
        expect_track(1'b0, 0);
        wait_done("cold");
        chk("cold_sec", 32'(track_sec), SPT - 1);
        chk("cold_dirty", 32'(dirty), 0);
        m_cur = 0;
        m_dirty = 1'b0;
        // clean seek
        track = 6'd5;
        expect_track(1'b0, 5);
        wait_done("clean");
        // dirty seek
        pulse_wr();
        chk("dseek_dirty_set", 32'(dirty), 1);
        track = 6'd6;
        expect_track(1'b1, 5);
        expect_track(1'b0, 6);
        wait_done("dseek");
        chk("dseek_dirty_clr", 32'(dirty), 0);
        // readonly image ignores writes
        img_readonly = 1'b1;
        pulse_wr();
        chk("ro_dirty", 32'(dirty), 0);
        track = 6'd2;
        expect_track(1'b0, 2);
        wait_done("ro");
        chk("ro_dirty_end", 32'(dirty), 0);
        img_readonly = 1'b0;
        // remount during LOAD, core writes during LOAD ignored
        pulse_wr();
        track = 6'd9;
        expect_track(1'b1, 2);
        expect_track(1'b0, 9);
        expect_track(1'b0, 9);
        wait_sec(1'b0, 4);
        img_mounted = 1'b1;
        core_wr = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        core_wr = 1'b0;
        wait_done("remount");
        chk("remount_dirty", 32'(dirty), 0);
        m_cur = 9;
        m_dirty = 1'b0;
        // randomized writes/seeks against the track-level model
        for (int k = 0; k < 8; k++) begin
            ro = 1'($urandom_range(0, 1));
            img_readonly = ro;
            if ($urandom_range(0, 1) == 1) begin
                pulse_wr();
                if (!ro) m_dirty = 1'b1;
            end else @(negedge clk_sys);
            chk("rnd_dirty_pre", 32'(dirty), 32'(m_dirty));
            t = int'($urandom_range(0, 63));
            if (t != m_cur) begin
                track = 6'(t);
                if (m_dirty && !ro) begin
                    expect_track(1'b1, m_cur);
                    m_dirty = 1'b0;
                end
                expect_track(1'b0, t);
                m_cur = t;
                wait_done("rnd");
            end
            chk("rnd_dirty_post", 32'(dirty), 32'(m_dirty));
        end
        img_readonly = 1'b0;
        // reset in the middle of a write-back
        if (!m_dirty) pulse_wr();
        t = (m_cur + 1) % 64;
        track = 6'(t);
        wait_sec(1'b1, 7);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("mrst_rd", 32'(sd_rd), 0);
        chk("mrst_wr", 32'(sd_wr), 0);
        chk("mrst_wait", 32'(cpu_wait), 0);
        chk("mrst_dirty", 32'(dirty), 0);
        chk("mrst_lba", sd_lba, 0);
        chk("mrst_sec", 32'(track_sec), 0);
        repeat (2) @(negedge clk_sys);
        got_lba.delete();
        got_wr.delete();
        exp_lba.delete();
        exp_wr.delete();
        reset_n = 1'b1;
        expect_track(1'b0, t);
        wait_done("post_rst");
        chk("post_rst_dirty", 32'(dirty), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
